// File: rtl/serial_word_rx_pkg.sv
// Shared types and defaults for the serial word receiver.
// FSM state encoding plus default word width and sync word.
package serial_word_rx_pkg;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } rx_state_e;

    localparam int unsigned DEF_WORD_W       = 8;
    localparam logic [31:0] DEF_SYNC_PATTERN = 32'h0000_00A5;

endpackage

// File: rtl/serial_word_rx_outreg.sv
// One-entry valid/ready holding register with sticky overflow and load counter.
// Latency 1 from load to word_vld_o; a load arriving while full and not draining is dropped.
module serial_word_rx_outreg #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_vld_i,
    input  logic [WORD_W-1:0] load_dat_i,
    input  logic              word_rdy_i,
    output logic [WORD_W-1:0] word_dat_o,
    output logic              word_vld_o,
    output logic [15:0]       word_count_o,
    output logic              overflow_o
);

    logic [WORD_W-1:0] dat_q, dat_d;
    logic              vld_q, vld_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              drain;
    logic              can_load;

    assign drain    = vld_q && word_rdy_i;
    assign can_load = !vld_q || word_rdy_i;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (load_vld_i && can_load) begin
            dat_d = load_dat_i;
            vld_d = 1'b1;
            cnt_d = cnt_q + 16'd1;
        end else if (load_vld_i) begin
            ovf_d = 1'b1;
        end else if (drain) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign word_dat_o   = dat_q;
    assign word_vld_o   = vld_q;
    assign word_count_o = cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial-to-word assembler feeding a one-entry valid/ready output register.
// Optional sync-word hunt before each frame: define SERIAL_WORD_RX_SYNC_HUNT_EN.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int unsigned       WORD_W       = DEF_WORD_W,
    parameter int unsigned       FRAME_WORDS  = 4,
    parameter logic [WORD_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN[WORD_W-1:0]
) (
    input  logic              qzt_clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              bit_en,
    input  logic              restart,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [15:0]       word_count,
    output logic              overflow,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
    localparam logic [15:0]      FRAME_LAST = 16'(FRAME_WORDS - 1);

`ifdef SERIAL_WORD_RX_SYNC_HUNT_EN
    localparam bit        HUNT_EN   = 1'b1;
    localparam rx_state_e RST_STATE = ST_HUNT;
`else
    localparam bit        HUNT_EN   = 1'b0;
    localparam rx_state_e RST_STATE = ST_COLLECT;
`endif

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [WORD_W-1:0] shift_next;
    logic              word_done;

    // Window including the current bit; also the completed word on the last bit.
    assign shift_next = {serial_in, shreg_q[WORD_W-1:1]};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        word_done   = 1'b0;
        if (restart) begin
            shreg_d     = '0;
            bit_cnt_d   = '0;
            frame_cnt_d = '0;
            if (HUNT_EN) begin
                state_d = ST_HUNT;
            end
        end else if (bit_en) begin
            shreg_d = shift_next;
            if (state_q == ST_COLLECT) begin
                if (bit_cnt_q == LAST_BIT) begin
                    word_done = 1'b1;
                    bit_cnt_d = '0;
                    // Dropped words still count toward the frame length.
                    if (HUNT_EN && frame_cnt_q == FRAME_LAST) begin
                        state_d     = ST_HUNT;
                        frame_cnt_d = '0;
                        shreg_d     = '0;
                    end else if (HUNT_EN) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end else if (shift_next == SYNC_PATTERN) begin
                state_d     = ST_COLLECT;
                shreg_d     = '0;
                bit_cnt_d   = '0;
                frame_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q     <= RST_STATE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef SERIAL_WORD_RX_SYNC_HUNT_EN
    assign locked = (state_q == ST_COLLECT);
`else
    assign locked = 1'b1;
`endif

    serial_word_rx_outreg #(
        .WORD_W (WORD_W)
    ) u_outreg (
        .clk          (qzt_clk),
        .reset        (reset),
        .load_vld_i   (word_done),
        .load_dat_i   (shift_next),
        .word_rdy_i   (word_ready),
        .word_dat_o   (word_out),
        .word_vld_o   (word_valid),
        .word_count_o (word_count),
        .overflow_o   (overflow)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed self-checking bench for serial_word_rx (WORD_W=8).
module tb_serial_word_rx;

    logic        qzt_clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_in = 1'b0;
    logic        bit_en = 1'b0;
    logic        restart = 1'b0;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [15:0] word_count;
    logic        overflow;
    logic        locked;

    int checks = 0;
    int errors = 0;

    serial_word_rx dut (
        .qzt_clk    (qzt_clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .restart    (restart),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_count (word_count),
        .overflow   (overflow),
        .locked     (locked)
    );

    always #5 qzt_clk = ~qzt_clk;

    // Inputs set before tick are consumed at the posedge; outputs read 1 time unit later.
    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_en    = 1'b1;
        tick();
        bit_en    = 1'b0;
    endtask

    // Sends the first n bits of w, LSB first, back to back.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", word_out); end
        checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", word_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`ifndef SERIAL_WORD_RX_SYNC_HUNT_EN
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked: got %b expected 1", locked); end
`endif
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_bits(8'h5A, 7);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", word_valid); end
        send_bit(1'b0);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", word_valid); end
        checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL basic_out: got %h expected 5a", word_out); end
        checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", word_count); end
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", word_valid); end
        checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL basic_hold: got %h expected 5a", word_out); end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        w = 8'h5A;
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            if (i < 7) begin
                idle(1);
                checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL gap_early%0d: got %b expected 0", i, word_valid); end
            end
        end
        checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL gap_out: got %h expected 5a", word_out); end
        checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL gap_count: got %0d expected 2", word_count); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send_bits(8'h5A, 8);
        send_bits(8'hC3, 7);
        word_ready = 1'b1;
        send_bit(1'b1);
        checks++; if (word_out !== 8'hC3) begin errors++; $display("FAIL b2b_out: got %h expected c3", word_out); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", word_valid); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", word_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", word_valid); end
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_bits(8'h5A, 8);
        send_bits(8'hC3, 8);
        checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL bp_out: got %h expected 5a", word_out); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
        checks++; if (word_count !== 16'd5) begin errors++; $display("FAIL bp_count: got %0d expected 5", word_count); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", word_valid); end
        word_ready = 1'b1;
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", word_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_restart();
        word_ready = 1'b1;
        send_bits(8'hFF, 5);
        restart = 1'b1;
        send_bit(1'b1);
        restart = 1'b0;
        send_bits(8'hC3, 7);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_early: got %b expected 0", word_valid); end
        checks++; if (word_count !== 16'd5) begin errors++; $display("FAIL rst_count_hold: got %0d expected 5", word_count); end
        checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL rst_out_hold: got %h expected 5a", word_out); end
        send_bit(1'b1);
        checks++; if (word_out !== 8'hC3) begin errors++; $display("FAIL rst_out: got %h expected c3", word_out); end
        checks++; if (word_count !== 16'd6) begin errors++; $display("FAIL rst_count: got %0d expected 6", word_count); end
        idle(1);
    endtask

`ifdef SERIAL_WORD_RX_SYNC_HUNT_EN
    task automatic test_sync_hunt();
        logic [7:0] frame [4];
        frame[0] = 8'h5A; frame[1] = 8'hC3; frame[2] = 8'h3C; frame[3] = 8'h81;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        word_ready = 1'b1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_reset_locked: got %b expected 0", locked); end
        send_bits(8'b0000_0011, 3);
        send_bits(8'hA5, 8);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sync_lock: got %b expected 1", locked); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_no_out: got %b expected 0", word_valid); end
        for (int k = 0; k < 4; k++) begin
            send_bits(frame[k], 8);
            checks++; if (word_out !== frame[k]) begin errors++; $display("FAIL sync_word%0d: got %h expected %h", k, word_out, frame[k]); end
        end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL sync_count: got %0d expected 4", word_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_unlock: got %b expected 0", locked); end
        send_bits(8'h5A, 8);
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL sync_ignore: got %0d expected 4", word_count); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL sync_ignore_vld: got %b expected 0", word_valid); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SERIAL_WORD_RX_SYNC_HUNT_EN
        test_basic();
        test_gapped();
        test_back_to_back();
        test_backpressure();
        test_restart();
        chk("final_count", word_count, 16'd6);
`else
        test_sync_hunt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Downstream consumer of the 31-bit serial shift stage's serial_out bitstream.
- Assembles bits, LSB-first, into WORD_W-bit words and presents them through a one-entry valid/ready output register to the readout or FIFO logic.
- Tracks accepted-word count and a sticky overflow flag.
- Optionally hunts for a sync word before collecting each frame.

Parameters:
- WORD_W, 8, bits per assembled word (2..32).
- FRAME_WORDS, 4, words collected per frame after sync (used only with the sync feature).
- SYNC_PATTERN, 8'hA5, WORD_W-bit sync word, LSB received first.

Ports:
- qzt_clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  bit from the upstream shifter's serial_out.
- bit_en  input  1  serial_in is a valid bit this cycle.
- restart  input  1  drop the partial word; pulsed alongside the upstream set/preset.
- word_out  output  WORD_W  assembled word, held stable while word_valid is high.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
- word_count  output  16  count of words loaded into the output register.
- overflow  output  1  sticky; a completed word was dropped.
- locked  output  1  in COLLECT state.

Behaviour:
- Reset (synchronous, active-high) clears everything:
  - shift register, bit_cnt, word_out, word_valid, word_count, overflow all 0.
  - State goes to HUNT (feature enabled) or COLLECT (feature disabled).
- Bit capture, on bit_en:
  - shreg <= {serial_in, shreg[WORD_W-1:1]}; the first bit received lands in bit 0 of the final word.
  - bit_cnt increments.
- Word completion: bit_en with bit_cnt==WORD_W-1 in COLLECT.
  - Completed word is {serial_in, shreg[WORD_W-1:1]}; bit_cnt returns to 0.
- Loading the output register:
  - Load if word_valid==0, or if word_valid && word_ready in the same cycle (simultaneous drain and load is allowed).
  - Word becomes visible with word_valid=1 on the cycle after the last bit (latency 1).
  - word_count increments on each load and wraps 0xFFFF -> 0.
- Otherwise (output register full and not draining):
  - Completed word is discarded; overflow <= 1.
  - word_out is unchanged and word_count is not incremented.
  - overflow clears only on reset.
- Drain: word_valid && word_ready with no new load -> word_valid <= 0 next cycle. word_out holds its last value.
- restart:
  - Clears shreg and bit_cnt; state -> HUNT (feature enabled).
  - Has priority over bit_en in the same cycle; that bit is discarded.
  - Does not touch word_out, word_valid, word_count or overflow.
- bit_en low: shreg and bit_cnt hold.
- Handshake is independent of bit_en; a drain can happen on any cycle.

Optional Feature:
- Macro: SERIAL_WORD_RX_SYNC_HUNT_EN.
- Defined, states are HUNT and COLLECT:
  - HUNT: each bit_en shifts a WORD_W window. When the window including the current bit equals SYNC_PATTERN -> COLLECT next cycle with bit_cnt=0. The sync word is not output.
  - COLLECT: after FRAME_WORDS completed words (loaded or dropped) -> HUNT.
  - A 16-bit frame-word counter supports this.
  - locked = (state==COLLECT).
- Undefined: permanently COLLECT; locked tied to 1; FRAME_WORDS and SYNC_PATTERN ignored.

Decomposition:
- Shared package holds:
  - state encoding constants ST_HUNT=1'b0, ST_COLLECT=1'b1;
  - default WORD_W;
  - SYNC_PATTERN default value.
- One natural sub-module: serial_word_rx_outreg, the one-entry valid/ready holding register with overflow detect. Shift, counter and FSM stay in the top.

Test Plan:
- Basic assembly: after reset, word_ready=1, bits 0,1,0,1,1,0,1,0 on consecutive bit_en cycles -> word_out=8'h5A, word_valid=1 one cycle after the 8th bit, word_count=1.
- Gapped input: same 8 bits with bit_en low every other cycle -> identical 8'h5A; shreg holds during gaps.
- Backpressure: word_ready=0 while 8'h5A then 8'hC3 complete -> word_out stays 8'h5A, overflow=1, word_count=1. Then word_ready=1 -> valid drops.
- Same-cycle drain and load: word_ready=1 exactly when the next word completes -> new word loads, no overflow, word_valid stays 1.
- restart after 5 bits, in the same cycle as a bit_en -> partial word discarded; the next 8 bits form a clean word; word_count and word_out unchanged until then. Wrap check: preload 0xFFFF loads, one more load -> word_count=0.
- SYNC_HUNT_EN: noise, then A5 LSB-first (1,0,1,0,0,1,0,1) -> locked=1 with no output. Next 4 words output, then locked=0. Bits after the 4th word are ignored until A5 recurs.
